spi_p2s_shifter: RTL and testbench

Parametrised SPI slave transmit path. Serialises a DATA_WIDTH-bit word onto MISO, one bit per shift_en strobe.
- Strobes come from the SCLK-edge detector in the system clock domain.
- A one-entry holding register accepts the next word through a valid/ready handshake, so consecutive words go out back-to-back with no bit gap.
- Sits between the slave's transmit data source and the MISO pad driver. Adds configurable bit order, idle level, a word-done pulse and underrun detection.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_p2s_shifter_if.sv | 15 +
 rtl/spi_tx_hold_reg.sv | 38 +++
 rtl/spi_p2s_shifter.sv | 114 +++++++++++
 tb/tb_spi_p2s_shifter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the transmit (P2S) and receive (S2P) paths.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } p2s_state_t;

endpackage

// File: rtl/spi_p2s_shifter_if.sv
// Transmit-word handshake between the data source (master) and the shifter (slave).
interface spi_p2s_shifter_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
) ();

    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/spi_tx_hold_reg.sv
// One-entry holding register: accepts a word on valid/ready, releases it on pop.
module spi_tx_hold_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    input  logic                  pop,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data
);

    logic accept;

    assign push_ready = !full;
    assign accept     = push_valid && !full;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // NOTE: the data word is not reset; full alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            data <= push_data;
        end
    end

endmodule

// File: rtl/spi_p2s_shifter.sv
// SPI slave transmit path: serialises held words onto MISO, one bit per shift_en strobe.
module spi_p2s_shifter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_p2s_shifter_if.slave        tx,
    input  logic                    shift_en,
    output logic                    MISO,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun,
    input  logic                    underrun_clr
);

    localparam int unsigned          CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(DATA_WIDTH - 2);

    p2s_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  load, shift_bit, last, starve;

    spi_tx_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (tx.tx_valid),
        .push_data  (tx.tx_data),
        .push_ready (tx.tx_ready),
        .pop        (load),
        .full       (hold_full),
        .data       (hold_data)
    );

    assign busy = (state_q == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        shift_bit = 1'b0;
        last      = 1'b0;
        starve    = 1'b0;
        case (state_q)
            IDLE: begin
                if (shift_en) begin
                    if (hold_full) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        starve  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    shift_bit = 1'b1;
                    if (bit_cnt_q == '0) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The shift register always presents the next bit at the end selected by MSB_FIRST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MISO      <= IDLE_LEVEL;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            done      <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                MISO      <= MSB_FIRST ? hold_data[DATA_WIDTH-1] : hold_data[0];
                shift_q   <= MSB_FIRST ? (hold_data << 1) : (hold_data >> 1);
                bit_cnt_q <= CNT_LOAD;
            end else if (shift_bit) begin
                MISO    <= MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
                shift_q <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                if (!last) begin
                    bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                end
            end else if (starve) begin
                MISO <= IDLE_LEVEL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_p2s_shifter.sv
// Bench for spi_p2s_shifter: three configurations checked every cycle against a word-level model.
module tb_spi_p2s_shifter;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0] drv_valid, drv_shift, drv_clr;
    logic [15:0]     drv_data [NDUT];
    logic [NDUT-1:0] o_miso, o_busy, o_done, o_ur, o_ready;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt [NDUT];
    logic [15:0] seq;

    // Configurations: 0 = 8b MSB-first idle 0, 1 = 8b LSB-first idle 1, 2 = 16b MSB-first idle 0.
    function automatic int dw(input int d);
        return (d == 2) ? 16 : 8;
    endfunction
    function automatic logic msb(input int d);
        return (d != 1);
    endfunction
    function automatic logic idle(input int d);
        return (d == 1);
    endfunction
    function automatic logic bit_of(input int d, input logic [15:0] word, input int k);
        return msb(d) ? word[dw(d) - 1 - k] : word[k];
    endfunction

    spi_p2s_shifter_if #(.DATA_WIDTH(8))  ifc0 ();
    spi_p2s_shifter_if #(.DATA_WIDTH(8))  ifc1 ();
    spi_p2s_shifter_if #(.DATA_WIDTH(16)) ifc2 ();

    assign ifc0.tx_valid = drv_valid[0];
    assign ifc0.tx_data  = drv_data[0][7:0];
    assign o_ready[0]    = ifc0.tx_ready;
    assign ifc1.tx_valid = drv_valid[1];
    assign ifc1.tx_data  = drv_data[1][7:0];
    assign o_ready[1]    = ifc1.tx_ready;
    assign ifc2.tx_valid = drv_valid[2];
    assign ifc2.tx_data  = drv_data[2];
    assign o_ready[2]    = ifc2.tx_ready;

    spi_p2s_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx(ifc0), .shift_en(drv_shift[0]), .MISO(o_miso[0]),
        .busy(o_busy[0]), .done(o_done[0]), .underrun(o_ur[0]), .underrun_clr(drv_clr[0]));
    spi_p2s_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx(ifc1), .shift_en(drv_shift[1]), .MISO(o_miso[1]),
        .busy(o_busy[1]), .done(o_done[1]), .underrun(o_ur[1]), .underrun_clr(drv_clr[1]));
    spi_p2s_shifter #(.DATA_WIDTH(16), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx(ifc2), .shift_en(drv_shift[2]), .MISO(o_miso[2]),
        .busy(o_busy[2]), .done(o_done[2]), .underrun(o_ur[2]), .underrun_clr(drv_clr[2]));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: a held slot, the word in flight and how many of its bits remain.
    logic        m_full [NDUT];
    logic [15:0] m_hold [NDUT];
    logic [15:0] m_word [NDUT];
    int          m_left [NDUT];
    logic        m_miso [NDUT];
    logic        m_done [NDUT];
    logic        m_ur   [NDUT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                m_full[d] <= 1'b0;
                m_hold[d] <= '0;
                m_word[d] <= '0;
                m_left[d] <= 0;
                m_miso[d] <= idle(d);
                m_done[d] <= 1'b0;
                m_ur[d]   <= 1'b0;
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                logic full_n, miso_n, done_n, ur_n, starve;
                logic [15:0] hold_n, word_n;
                int left_n;
                full_n = m_full[d]; hold_n = m_hold[d]; word_n = m_word[d];
                left_n = m_left[d]; miso_n = m_miso[d]; ur_n = m_ur[d];
                done_n = 1'b0; starve = 1'b0;
                if (drv_shift[d]) begin
                    if (m_left[d] > 0) begin
                        miso_n = bit_of(d, m_word[d], dw(d) - m_left[d]);
                        left_n = m_left[d] - 1;
                        done_n = (left_n == 0);
                    end else if (m_full[d]) begin
                        word_n = m_hold[d];
                        full_n = 1'b0;
                        miso_n = bit_of(d, m_hold[d], 0);
                        left_n = dw(d) - 1;
                    end else begin
                        miso_n = idle(d);
                        starve = 1'b1;
                    end
                end
                if (starve)          ur_n = 1'b1;
                else if (drv_clr[d]) ur_n = 1'b0;
                if (drv_valid[d] && !m_full[d]) begin
                    full_n = 1'b1;
                    hold_n = drv_data[d];
                end
                m_full[d] <= full_n; m_hold[d] <= hold_n; m_word[d] <= word_n;
                m_left[d] <= left_n; m_miso[d] <= miso_n; m_done[d] <= done_n; m_ur[d] <= ur_n;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("miso dut%0d", d),  16'(o_miso[d]),  16'(m_miso[d]));
            check($sformatf("busy dut%0d", d),  16'(o_busy[d]),  16'(m_left[d] > 0));
            check($sformatf("done dut%0d", d),  16'(o_done[d]),  16'(m_done[d]));
            check($sformatf("ur dut%0d", d),    16'(o_ur[d]),    16'(m_ur[d]));
            check($sformatf("ready dut%0d", d), 16'(o_ready[d]), 16'(!m_full[d]));
            if (o_done[d]) done_cnt[d]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [15:0] data);
        bit ok = 1'b0;
        drv_valid[d] = 1'b1;
        drv_data[d]  = data;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = o_ready[d];
            tick();
        end
        drv_valid[d] = 1'b0;
        if (!ok) check("load timeout", 16'd0, 16'd1);
    endtask

    task automatic strobes(input int d, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drv_shift[d] = 1'b1;
            tick();
            drv_shift[d] = 1'b0;
            seq = {seq[14:0], o_miso[d]};
            if (i < n - 1) repeat (gap) tick();
        end
    endtask

    initial begin
        int dc;
        drv_valid = '0; drv_shift = '0; drv_clr = '0;
        for (int d = 0; d < NDUT; d++) begin
            drv_data[d] = '0;
            done_cnt[d] = 0;
        end
        seq = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset miso", 16'(o_miso), 16'b010);
        check("reset busy", 16'(o_busy), 16'b000);
        check("reset ready", 16'(o_ready), 16'b111);
        check("reset ur", 16'(o_ur), 16'b000);

        // MSB-first A5 with spaced strobes
        load(0, 16'h00A5);
        strobes(0, 8, 4);
        check("a5 seq", seq[7:0], 16'h00A5);
        check("a5 done", 16'(o_done[0]), 16'd1);
        check("a5 busy after", 16'(o_busy[0]), 16'd0);
        tick();
        check("a5 done pulse", 16'(o_done[0]), 16'd0);

        // LSB-first 01
        load(1, 16'h0001);
        strobes(1, 8, 2);
        check("lsb 01 seq", seq[7:0], 16'h0080);

        // back-to-back F0 then 0F
        load(0, 16'h00F0);
        dc = done_cnt[0];
        fork
            strobes(0, 16, 0);
            begin
                repeat (3) tick();
                load(0, 16'h000F);
            end
        join
        tick();
        check("b2b seq", seq, 16'hF00F);
        check("b2b dones", 16'(done_cnt[0] - dc), 16'd2);
        check("b2b ur", 16'(o_ur[0]), 16'd0);

        // valid held while full must not overwrite the held word
        load(0, 16'h005A);
        drv_valid[0] = 1'b1;
        drv_data[0]  = 16'h003C;
        repeat (3) tick();
        strobes(0, 8, 1);
        drv_valid[0] = 1'b0;
        check("hold seq", seq[7:0], 16'h005A);
        strobes(0, 8, 1);
        check("next seq", seq[7:0], 16'h003C);

        // underrun: sticky, clear, and set winning over clear
        tick();
        strobes(0, 1, 0);
        check("ur miso", 16'(o_miso[0]), 16'd0);
        check("ur set", 16'(o_ur[0]), 16'd1);
        repeat (2) tick();
        check("ur sticky", 16'(o_ur[0]), 16'd1);
        drv_clr[0] = 1'b1;
        tick();
        drv_clr[0] = 1'b0;
        check("ur clr", 16'(o_ur[0]), 16'd0);
        drv_clr[0] = 1'b1;
        strobes(0, 1, 0);
        drv_clr[0] = 1'b0;
        check("ur set wins", 16'(o_ur[0]), 16'd1);

        // accept in the same cycle as an empty strobe on the LSB-first idle-1 config
        drv_valid[1] = 1'b1;
        drv_data[1]  = 16'h0035;
        strobes(1, 1, 0);
        drv_valid[1] = 1'b0;
        check("acc ur", 16'(o_ur[1]), 16'd1);
        check("acc miso idle", 16'(o_miso[1]), 16'd1);
        check("acc ready", 16'(o_ready[1]), 16'd0);
        strobes(1, 8, 1);
        check("acc seq", seq[7:0], 16'h00AC);

        // 16-bit word cut short by asynchronous reset
        load(2, 16'h8001);
        strobes(2, 5, 2);
        check("w16 partial", 16'(seq[4:0]), 16'h0010);
        check("w16 busy", 16'(o_busy[2]), 16'd1);
        rst_n = 1'b0;
        #1;
        check("rst miso", 16'(o_miso[2]), 16'd0);
        check("rst busy", 16'(o_busy[2]), 16'd0);
        check("rst ready", 16'(o_ready[2]), 16'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        strobes(2, 1, 0);
        check("post rst ur", 16'(o_ur[2]), 16'd1);
        check("post rst miso", 16'(o_miso[2]), 16'd0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
